// File: rtl/decode_queue.sv
// Decode stage for the RV32I core: a DEPTH-entry instruction FIFO whose head is
// decoded into a registered control bundle, with valid/ready on both sides and flush.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [4:0]               out_alu_sel,
  output logic                     out_b_sel,
  output logic                     out_pc_sel,
  output logic                     out_brn_en,
  output logic [2:0]               out_brn_ctl,
  output logic                     out_jump,
  output logic                     out_d_rw,
  output logic                     out_mem_rd,
  output logic [1:0]               out_wb_sel,
  output logic                     out_wb_en,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_sel;
    logic            b_sel;
    logic            pc_sel;
    logic            brn_en;
    logic [2:0]      brn_ctl;
    logic            jump;
    logic            d_rw;
    logic            mem_rd;
    wb_sel_e         wb_sel;
    logic            wb_en;
    logic            illegal;
  } bundle_t;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, load;
  logic [31:0]     head;
  opcode_e         opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm32;
  bundle_t         dec, bundle_q;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign load     = (!out_valid || out_ready) && (count != '0) && !flush;

  assign head   = inst_mem[rd_ptr];
  assign opcode = opcode_e'(head[6:0]);
  assign funct3 = head[14:12];
  assign funct7 = head[31:25];

  // NOTE: the storage array is deliberately left out of reset; count and the
  // pointers alone define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec     = '0;
    imm32   = '0;
    dec.pc  = pc_mem[rd_ptr];
    dec.rd  = head[11:7];
    dec.rs1 = head[19:15];
    dec.rs2 = head[24:20];
    case (opcode)
      OPC_OP: begin
        dec.alu_sel = {funct7 == 7'b0000001, funct7[5], funct3};
        dec.wb_sel  = WB_ALU;
        dec.wb_en   = 1'b1;
        dec.illegal = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                        (funct7 == 7'b0000001 && EN_M));
      end
      OPC_OP_IMM: begin
        imm32       = {{20{head[31]}}, head[31:20]};
        dec.alu_sel = {1'b0, (funct3 == 3'b101) && funct7[5], funct3};
        // Shifts take the shamt from the rs2 field rather than the immediate.
        dec.b_sel   = !(funct3 == 3'b001 || funct3 == 3'b101);
        dec.wb_sel  = WB_ALU;
        dec.wb_en   = 1'b1;
      end
      OPC_LOAD: begin
        imm32      = {{20{head[31]}}, head[31:20]};
        dec.b_sel  = 1'b1;
        dec.mem_rd = 1'b1;
        dec.wb_sel = WB_MEM;
        dec.wb_en  = 1'b1;
      end
      OPC_STORE: begin
        imm32     = {{20{head[31]}}, head[31:25], head[11:7]};
        dec.b_sel = 1'b1;
        dec.d_rw  = 1'b1;
      end
      OPC_BRANCH: begin
        imm32       = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        dec.pc_sel  = 1'b1;
        dec.b_sel   = 1'b1;
        dec.brn_en  = 1'b1;
        dec.brn_ctl = funct3;
        dec.illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_JAL: begin
        imm32      = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
        dec.pc_sel = 1'b1;
        dec.b_sel  = 1'b1;
        dec.jump   = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.wb_en  = 1'b1;
      end
      OPC_JALR: begin
        imm32      = {{20{head[31]}}, head[31:20]};
        dec.b_sel  = 1'b1;
        dec.jump   = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.wb_en  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32      = {head[31:12], 12'h000};
        dec.b_sel  = 1'b1;
        dec.pc_sel = (opcode == OPC_AUIPC);
        dec.wb_sel = WB_ALU;
        dec.wb_en  = 1'b1;
      end
      OPC_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (dec.illegal) begin
      dec.wb_en  = 1'b0;
      dec.d_rw   = 1'b0;
      dec.mem_rd = 1'b0;
      dec.jump   = 1'b0;
      dec.brn_en = 1'b0;
    end
    if (dec.rd == 5'd0) dec.wb_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(load);
      if (load) begin
        out_valid <= 1'b1;
        bundle_q  <= dec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_pc      = bundle_q.pc;
  assign out_rd      = bundle_q.rd;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_imm     = bundle_q.imm;
  assign out_alu_sel = bundle_q.alu_sel;
  assign out_b_sel   = bundle_q.b_sel;
  assign out_pc_sel  = bundle_q.pc_sel;
  assign out_brn_en  = bundle_q.brn_en;
  assign out_brn_ctl = bundle_q.brn_ctl;
  assign out_jump    = bundle_q.jump;
  assign out_d_rw    = bundle_q.d_rw;
  assign out_mem_rd  = bundle_q.mem_rd;
  assign out_wb_sel  = bundle_q.wb_sel;
  assign out_wb_en   = bundle_q.wb_en;
  assign out_illegal = bundle_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: hand-checked decode table, stall/flush/reset sequences,
// and random traffic against a queue-based reference, on EN_M=0 and EN_M=1 copies.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic in_ready, out_valid, out_b_sel, out_pc_sel, out_brn_en, out_jump, out_d_rw;
  logic out_mem_rd, out_wb_en, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2, out_alu_sel;
  logic [2:0] out_brn_ctl;
  logic [1:0] out_wb_sel;
  logic [CW-1:0] count;

  logic m_in_ready, m_out_valid, m_b_sel, m_pc_sel, m_brn_en, m_jump, m_d_rw;
  logic m_mem_rd, m_wb_en, m_illegal;
  logic [31:0] m_pc, m_imm;
  logic [4:0] m_rd, m_rs1, m_rs2, m_alu_sel;
  logic [2:0] m_brn_ctl;
  logic [1:0] m_wb_sel;
  logic [CW-1:0] m_count;

  always #5 clock = ~clock;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .EN_M(1'b0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_sel(out_alu_sel), .out_b_sel(out_b_sel), .out_pc_sel(out_pc_sel),
    .out_brn_en(out_brn_en), .out_brn_ctl(out_brn_ctl), .out_jump(out_jump),
    .out_d_rw(out_d_rw), .out_mem_rd(out_mem_rd), .out_wb_sel(out_wb_sel),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal), .count(count));

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .EN_M(1'b1)) dut_m (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_pc), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_imm(m_imm),
    .out_alu_sel(m_alu_sel), .out_b_sel(m_b_sel), .out_pc_sel(m_pc_sel),
    .out_brn_en(m_brn_en), .out_brn_ctl(m_brn_ctl), .out_jump(m_jump),
    .out_d_rw(m_d_rw), .out_mem_rd(m_mem_rd), .out_wb_sel(m_wb_sel),
    .out_wb_en(m_wb_en), .out_illegal(m_illegal), .count(m_count));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [4:0]  alu_sel;
    logic        b_sel, pc_sel, brn_en;
    logic [2:0]  brn_ctl;
    logic        jump, d_rw, mem_rd;
    logic [1:0]  wb_sel;
    logic        wb_en, illegal;
  } bundle_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        b_sel, pc_sel, brn_en;
    logic [2:0]  ctl;
    logic        jump, d_rw, mem_rd;
    logic [1:0]  wb_sel;
    logic        wb_en, ill;
    logic [4:0]  m_alu;
    logic        m_wb_en, m_ill;
  } vec_t;

  bundle_t dut_b, m_b;
  assign dut_b = {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_sel, out_b_sel, out_pc_sel,
                  out_brn_en, out_brn_ctl, out_jump, out_d_rw, out_mem_rd, out_wb_sel,
                  out_wb_en, out_illegal};
  assign m_b = {m_pc, m_rd, m_rs1, m_rs2, m_imm, m_alu_sel, m_b_sel, m_pc_sel,
                m_brn_en, m_brn_ctl, m_jump, m_d_rw, m_mem_rd, m_wb_sel, m_wb_en, m_illegal};

  entry_t q[$];
  bit     m_valid;
  entry_t m_out;
  bit     acc;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written straight from the instruction-class rules.
  function automatic bundle_t ref_decode(input entry_t e, input bit en_m);
    bundle_t r;
    logic [31:0] x;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] i_imm;
    x  = e.inst;
    f7 = x[31:25];
    f3 = x[14:12];
    i_imm = $signed(x) >>> 20;
    r = '0;
    r.pc = e.pc; r.rd = x[11:7]; r.rs1 = x[19:15]; r.rs2 = x[24:20];
    case (x[6:0])
      7'b0110011: begin
        r.wb_sel = 2'd1; r.wb_en = 1'b1;
        r.alu_sel = {f7 == 7'h01, f7[5], f3};
        r.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                      (f7 == 7'h01 && en_m));
      end
      7'b0010011: begin
        r.imm = i_imm; r.wb_sel = 2'd1; r.wb_en = 1'b1;
        r.b_sel = (f3 != 3'd1 && f3 != 3'd5);
        r.alu_sel = {1'b0, f3 == 3'd5 && f7[5], f3};
      end
      7'b0000011: begin r.imm = i_imm; r.b_sel = 1'b1; r.mem_rd = 1'b1; r.wb_en = 1'b1; end
      7'b0100011: begin
        r.imm = (i_imm & ~32'h1F) | {27'd0, x[11:7]};
        r.b_sel = 1'b1; r.d_rw = 1'b1;
      end
      7'b1100011: begin
        r.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
        r.pc_sel = 1'b1; r.b_sel = 1'b1; r.brn_en = 1'b1; r.brn_ctl = f3;
        r.illegal = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'b1101111: begin
        r.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
        r.pc_sel = 1'b1; r.b_sel = 1'b1; r.jump = 1'b1; r.wb_sel = 2'd2; r.wb_en = 1'b1;
      end
      7'b1100111: begin
        r.imm = i_imm; r.b_sel = 1'b1; r.jump = 1'b1; r.wb_sel = 2'd2; r.wb_en = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        r.imm = x & 32'hFFFF_F000; r.b_sel = 1'b1; r.wb_sel = 2'd1; r.wb_en = 1'b1;
        r.pc_sel = (x[6:0] == 7'b0010111);
      end
      7'b1110011: ;
      default: r.illegal = 1'b1;
    endcase
    if (r.illegal) begin
      r.wb_en = 1'b0; r.d_rw = 1'b0; r.mem_rd = 1'b0; r.jump = 1'b0; r.brn_en = 1'b0;
    end
    if (r.rd == 5'd0) r.wb_en = 1'b0;
    return r;
  endfunction

  // One clock: predict from pre-edge model state, advance the model, compare.
  task automatic step();
    bit push, load;
    push = in_valid && (q.size() < DEPTH) && !flush && !reset;
    load = (!m_valid || out_ready) && (q.size() > 0) && !flush && !reset;
    acc  = push;
    @(posedge clock);
    if (reset || flush) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      if (load) begin
        m_out   = q.pop_front();
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (push) q.push_back({in_inst, in_pc});
    end
    #1;
    check("count", count, q.size());
    check("in_ready", in_ready, q.size() < DEPTH);
    check("out_valid", out_valid, m_valid);
    check("m_count", m_count, q.size());
    check("m_out_valid", m_out_valid, m_valid);
    if (m_valid) begin
      check("bundle", dut_b, ref_decode(m_out, 1'b0));
      check("m_bundle", m_b, ref_decode(m_out, 1'b1));
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [6:0] ops [10];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    x = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) x[6:0] = ops[k];
    if (x[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: x[31:25] = 7'h00;
        1: x[31:25] = 7'h20;
        2: x[31:25] = 7'h01;
        default: ;
      endcase
    end
    return x;
  endfunction

  initial begin
    vec_t vecs[12];
    bundle_t exp_b, exp_m;
    logic [31:0] got[$];
    int idx;

    vecs[0]  = '{32'h00510093, 32'd5,        5'b00000, 1,0,0,3'd0,0,0,0,2'd1,1,0, 5'b00000,1,0};
    vecs[1]  = '{32'h402081B3, 32'd0,        5'b01000, 0,0,0,3'd0,0,0,0,2'd1,1,0, 5'b01000,1,0};
    vecs[2]  = '{32'h022081B3, 32'd0,        5'b10000, 0,0,0,3'd0,0,0,0,2'd1,0,1, 5'b10000,1,0};
    vecs[3]  = '{32'h00000463, 32'd8,        5'b00000, 1,1,1,3'd0,0,0,0,2'd0,0,0, 5'b00000,0,0};
    vecs[4]  = '{32'h010000EF, 32'd16,       5'b00000, 1,1,0,3'd0,1,0,0,2'd2,1,0, 5'b00000,1,0};
    vecs[5]  = '{32'hFFC32283, 32'hFFFFFFFC, 5'b00000, 1,0,0,3'd0,0,0,1,2'd0,1,0, 5'b00000,1,0};
    vecs[6]  = '{32'h00742623, 32'd12,       5'b00000, 1,0,0,3'd0,0,1,0,2'd0,0,0, 5'b00000,0,0};
    vecs[7]  = '{32'h12345197, 32'h12345000, 5'b00000, 1,1,0,3'd0,0,0,0,2'd1,1,0, 5'b00000,1,0};
    vecs[8]  = '{32'h00002063, 32'd0,        5'b00000, 1,1,0,3'd2,0,0,0,2'd0,0,1, 5'b00000,0,1};
    vecs[9]  = '{32'h0000007F, 32'd0,        5'b00000, 0,0,0,3'd0,0,0,0,2'd0,0,1, 5'b00000,0,1};
    vecs[10] = '{32'h00100013, 32'd1,        5'b00000, 1,0,0,3'd0,0,0,0,2'd1,0,0, 5'b00000,0,0};
    vecs[11] = '{32'h40335293, 32'h403,      5'b01101, 0,0,0,3'd0,0,0,0,2'd1,1,0, 5'b01101,1,0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    m_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_bundle", dut_b, '0);
    check("reset_m_bundle", m_b, '0);
    step();
    check("ready_after_reset", in_ready, 1'b1);

    // Decode table: push, see it two edges later, then consume it.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h100 + 32'(4 * i); out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      exp_b = {in_pc, vecs[i].inst[11:7], vecs[i].inst[19:15], vecs[i].inst[24:20],
               vecs[i].imm, vecs[i].alu, vecs[i].b_sel, vecs[i].pc_sel, vecs[i].brn_en,
               vecs[i].ctl, vecs[i].jump, vecs[i].d_rw, vecs[i].mem_rd, vecs[i].wb_sel,
               vecs[i].wb_en, vecs[i].ill};
      exp_m = exp_b;
      exp_m.alu_sel = vecs[i].m_alu;
      exp_m.wb_en   = vecs[i].m_wb_en;
      exp_m.illegal = vecs[i].m_ill;
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_bundle", i), dut_b, exp_b);
      check($sformatf("vec%0d_m_bundle", i), m_b, exp_m);
      step();
    end

    // Stall with out_ready low, then drain through the pointer wrap.
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < DEPTH + 2);
      in_inst = 32'h00000093 | (32'(idx) << 20); in_pc = 32'h200 + 32'(4 * idx);
      step();
      if (acc) idx++;
    end
    check("full_count", count, DEPTH);
    check("full_in_ready", in_ready, 1'b0);
    check("stall_pc", out_pc, 32'h200);
    check("stall_imm", out_imm, 32'd0);
    got.push_back(out_pc);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < DEPTH + 2);
      in_inst = 32'h00000093 | (32'(idx) << 20); in_pc = 32'h200 + 32'(4 * idx);
      step();
      if (acc) idx++;
      if (out_valid) got.push_back(out_pc);
    end
    in_valid = 1'b0;
    check("drain_len", got.size(), DEPTH + 2);
    for (int k = 0; k < got.size(); k++)
      check($sformatf("drain_pc%0d", k), got[k], 32'h200 + 32'(4 * k));

    // Flush with three queued and a valid bundle; the concurrent push is dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300 + 32'(4 * k);
      step();
    end
    check("pre_flush_count", count, 3);
    check("pre_flush_valid", out_valid, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3F0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    check("flush_push_dropped", out_valid, 1'b0);

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_inst = 32'hFFC32283; in_pc = 32'h400 + 32'(4 * k);
      step();
    end
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_valid", out_valid, 1'b0);
    check("midreset_count", count, 0);
    check("midreset_bundle", dut_b, '0);
    check("midreset_m_bundle", m_b, '0);
    step();

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
